// File: rtl/cipher_pkg.sv
// Shared types, widths and rotate helpers for the 9-bit add-rotate-xor sequencer.
package cipher_pkg;

   localparam int WORD_W = 9;
   localparam int ADDR_W = 2;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ROUND = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Doubling the word makes a rotate a plain shift plus a slice.
   function automatic logic [WORD_W-1:0] rotl9(input logic [WORD_W-1:0] x, input int unsigned n);
      logic [2*WORD_W-1:0] w;
      w = {x, x} << n;
      return w[2*WORD_W-1:WORD_W];
   endfunction

   function automatic logic [WORD_W-1:0] rotr9(input logic [WORD_W-1:0] x, input int unsigned n);
      logic [2*WORD_W-1:0] w;
      w = {x, x} >> n;
      return w[WORD_W-1:0];
   endfunction

endpackage

// File: rtl/cipher_seq_round.sv
// One combinational cipher round; encrypt and decrypt are exact inverses for the same k_r.
module cipher_round
   import cipher_pkg::*;
#(
   parameter int ROT = 3
) (
   input  logic [WORD_W-1:0] d,
   input  logic [WORD_W-1:0] k_r,
   input  logic              mode,
   output logic [WORD_W-1:0] d_next
);

   logic [WORD_W-1:0] t;

   // Encrypt: xor, rotate left, add.  Decrypt: subtract, rotate right, xor.
   always_comb begin
      t      = {WORD_W{1'b0}};
      d_next = {WORD_W{1'b0}};
      if (mode == MODE_ENC) begin
         t      = d ^ k_r;
         d_next = rotl9(t, ROT) + k_r;
      end else begin
         t      = rotr9(d - k_r, ROT);
         d_next = t ^ k_r;
      end
   end

endmodule

// File: rtl/cipher_seq.sv
// Register-file-attached cipher sequencer: read data and key, run ROUNDS rounds, write back.
module cipher_seq
   import cipher_pkg::*;
#(
   parameter int ROUNDS = 4,
   parameter int ROT    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] key_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   output logic              busy,
   output logic              done,
   output logic [WORD_W-1:0] result,
   output logic [ADDR_W-1:0] rf_rd0_addr,
   output logic [ADDR_W-1:0] rf_rd1_addr,
   input  logic [WORD_W-1:0] rf_rd0_data,
   input  logic [WORD_W-1:0] rf_rd1_data,
   output logic              rf_wr_en,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [WORD_W-1:0] rf_wr_data
);

   localparam int         RW     = 3;
   localparam logic [RW-1:0] R_LAST = RW'(ROUNDS - 1);

   state_t            state;
   logic              mode_q;
   logic [ADDR_W-1:0] dst_q;
   logic [WORD_W-1:0] d_q;
   logic [WORD_W-1:0] key_q;
   logic [RW-1:0]     r_q;
   logic [WORD_W-1:0] k_r;
   logic [WORD_W-1:0] d_next;
   logic              last_round;

   assign k_r        = key_q + {{(WORD_W-RW){1'b0}}, r_q};
   assign last_round = (mode_q == MODE_ENC) ? (r_q == R_LAST) : (r_q == {RW{1'b0}});

   cipher_round #(.ROT(ROT)) u_round (
      .d      (d_q),
      .k_r    (k_r),
      .mode   (mode_q),
      .d_next (d_next)
   );

   // Sequencer FSM; every output is a register updated on the state's edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= {WORD_W{1'b0}};
         rf_rd0_addr <= {ADDR_W{1'b0}};
         rf_rd1_addr <= {ADDR_W{1'b0}};
         rf_wr_en    <= 1'b0;
         rf_wr_addr  <= {ADDR_W{1'b0}};
         rf_wr_data  <= {WORD_W{1'b0}};
         mode_q      <= MODE_ENC;
         dst_q       <= {ADDR_W{1'b0}};
         d_q         <= {WORD_W{1'b0}};
         key_q       <= {WORD_W{1'b0}};
         r_q         <= {RW{1'b0}};
      end else begin
         done     <= 1'b0;
         rf_wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q      <= mode;
                  dst_q       <= dst_addr;
                  rf_rd0_addr <= src_addr;
                  rf_rd1_addr <= key_addr;
                  busy        <= 1'b1;
                  state       <= LOAD;
               end else begin
                  state <= IDLE;
               end
            end
            LOAD: begin
               // Operands are captured here, before any write-back, so aliasing is safe.
               d_q   <= rf_rd0_data;
               key_q <= rf_rd1_data;
               r_q   <= (mode_q == MODE_ENC) ? {RW{1'b0}} : R_LAST;
               state <= ROUND;
            end
            ROUND: begin
               d_q <= d_next;
               if (last_round) begin
                  state <= WRITE;
               end else begin
                  r_q   <= (mode_q == MODE_ENC) ? (r_q + 3'd1) : (r_q - 3'd1);
                  state <= ROUND;
               end
            end
            WRITE: begin
               rf_wr_en   <= 1'b1;
               rf_wr_addr <= dst_q;
               rf_wr_data <= d_q;
               state      <= DONE;
            end
            DONE: begin
               done   <= 1'b1;
               result <= d_q;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/cipher_seq.md
Name: cipher_seq

Overview:
- Sequencer that sits directly downstream of the 4x9-bit register file and also writes its result back into it.
- On start it:
  - reads a data word and a key word from the register file through the file's two read ports,
  - runs ROUNDS rounds of a 9-bit add-rotate-xor cipher (encrypt or decrypt),
  - writes the result to a destination register.
- Owns the register file's write port while busy.

Parameters:
- ROUNDS, 4, number of cipher rounds per operation (1..8).
- ROT, 3, left-rotate amount per round for encrypt (1..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: synchronous, active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- mode  in  1  0 = encrypt, 1 = decrypt.
- src_addr  in  2  register holding the input word.
- key_addr  in  2  register holding the key.
- dst_addr  in  2  register that receives the result.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  9  final cipher word; holds until the next accepted start.
- rf_rd0_addr  out  2  register file read port 0 address (data).
- rf_rd1_addr  out  2  register file read port 1 address (key).
- rf_rd0_data  in  9  register file read port 0 data (combinational read).
- rf_rd1_data  in  9  register file read port 1 data.
- rf_wr_en  out  1  register file write enable.
- rf_wr_addr  out  2  register file write address.
- rf_wr_data  out  9  register file write data.

Behaviour:
- Reset values (rst low at a clock edge): state IDLE; busy 0; done 0; result 0; rf_wr_en 0; all address outputs 0; rf_wr_data 0.
- Arithmetic: all values are 9-bit; add/subtract are mod 512.
- Round key k_r = key + r, for r = 0..ROUNDS-1.
- Encrypt round: t = d ^ k_r; d' = rotl9(t, ROT) + k_r.
  - Encrypt applies r = 0 up to ROUNDS-1.
- Decrypt round: t = rotr9(d - k_r, ROT); d' = t ^ k_r.
  - Decrypt applies r = ROUNDS-1 down to 0.
  - Decrypt exactly inverts encrypt for the same key.
- State machine:
  - IDLE: when start=1, latch mode and dst_addr; register rf_rd0_addr = src_addr and rf_rd1_addr = key_addr; go to LOAD. When start=0, stay.
  - LOAD: capture d = rf_rd0_data and key = rf_rd1_data; set r to 0 (encrypt) or ROUNDS-1 (decrypt); go to ROUND.
  - ROUND: one round per cycle, stepping r; after the round with r = ROUNDS-1 (encrypt) or r = 0 (decrypt), go to WRITE.
  - WRITE: rf_wr_en = 1 for exactly this cycle, with rf_wr_addr = dst and rf_wr_data = d; go to DONE.
  - DONE: done = 1 and result = d; go to IDLE.
- Latency: start sampled at edge 0 → done high during cycle ROUNDS+3; the write lands at edge ROUNDS+3.
  - Back-to-back throughput: one operation per ROUNDS+4 cycles.
- start while busy: ignored; no queuing.
- mode and address inputs are ignored except in the accept cycle.
- src_addr, key_addr and dst_addr may alias (any combination); operands are captured in LOAD before any write.
- rf_wr_en is never high outside WRITE. An external writer must not drive the register file while busy=1 (system rule, not checked here).
- Reset mid-operation: next state is IDLE with rf_wr_en 0; no partial write-back and no done pulse.
- Key = 0 and data = 511 are legal; wrap-around must follow the mod-512 rule.

Decomposition:
- Shared package cipher_pkg:
  - WORD_W = 9, ADDR_W = 2;
  - state enum {IDLE, LOAD, ROUND, WRITE, DONE};
  - MODE_ENC = 0, MODE_DEC = 1.
- One combinational sub-module, cipher_round: inputs d, k_r, mode; output d'. Parameterised by ROT; reused by the verification model.

Test Plan:
- With ROUNDS=1, load reg2=92 and reg1=65; encrypt src=2, key=1, dst=3 → rf_wr_data=297 to address 3 at edge 4, and done high with result=297 in cycle 4.
- With ROUNDS=1, load reg3=297 and reg1=65; decrypt src=3, key=1, dst=0 → write 92 to reg0, result=92.
- Default ROUNDS=4: encrypt reg0=12 with key reg3=255 into reg2, then decrypt reg2 with key reg3 into reg1 → reg1=12; each done arrives 7 cycles after start.
- Aliasing src=dst=key=1 with reg1=65, ROUNDS=1: encrypt → t=0, written value=65, reg1=65; start pulsed during ROUND is ignored (single done, busy continuous).
- Pull rst low in the cycle before WRITE → rf_wr_en never asserts, the destination register keeps its old value, no done pulse, and busy=0 after the edge.
- With ROUNDS=1, data=511 and key=0, encrypt → 511; then decrypt → 511 (wrap boundary).
